// File: rtl/stdout_line_assembler.sv
// Per-core line buffering of stdout FIFO characters; emits framed
// header + payload packets. Ports: FIFO in (valid/ready/data), stream out, drop count.
module stdout_line_assembler #(
  parameter int N_CLUSTERS = 4,
  parameter int N_CORES    = 8,
  parameter int LINE_LEN   = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic [15:0] drop_cnt_o
);

  localparam int NSLOT = N_CLUSTERS * N_CORES;
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int BW = $clog2(LINE_LEN);
  localparam logic [7:0] NCL = 8'(N_CLUSTERS);
  localparam logic [7:0] NCO = 8'(N_CORES);
  localparam logic [15:0] LL = 16'(LINE_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e state_q, state_d;

  logic [7:0]  buf_q [NSLOT][LINE_LEN];
  logic [15:0] len_q [NSLOT];

  logic [SW-1:0] sel_q;
  logic [7:0]    sel_cl_q, sel_core_q;
  logic [13:0]   wcnt_q;
  logic [15:0]   drop_q;

  logic [7:0]    cl, core, ch;
  logic [15:0]   slot_full;
  logic [SW-1:0] slot;
  logic [15:0]   cur_len;
  logic          in_range;

  logic [15:0]   sel_len;
  logic [15:0]   base;
  logic [15:0]   bi;
  logic [31:0]   pay_word;
  logic          is_last;

  logic wr_en, trig, drop_en, pay_hs, pay_done;

  logic unused_bits;

  assign cl   = in_data_i[23:16];
  assign core = in_data_i[15:8];
  assign ch   = in_data_i[7:0];

  assign in_range  = (cl < NCL) && (core < NCO);
  assign slot_full = 16'(cl) * 16'(N_CORES) + 16'(core);
  assign slot      = slot_full[SW-1:0];
  assign cur_len   = len_q[slot];

  assign unused_bits = ^{in_data_i[31:24], slot_full};

  assign sel_len = len_q[sel_q];
  assign base    = {wcnt_q, 2'b00};
  assign is_last = ({1'b0, base} + 17'd4) >= {1'b0, sel_len};

  // Bytes past the line end read as zero so the tail word is padded.
  always_comb begin
    pay_word = '0;
    bi = '0;
    for (int i = 0; i < 4; i++) begin
      bi = base + 16'(i);
      if (bi < sel_len)
        pay_word[8*i +: 8] = buf_q[sel_q][bi[BW-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    wr_en       = 1'b0;
    trig        = 1'b0;
    drop_en     = 1'b0;
    pay_hs      = 1'b0;
    pay_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = rst_ni;
        if (in_valid_i && rst_ni) begin
          unique case (1'b1)
            !in_range: drop_en = 1'b1;
            ch == 8'h0A: trig = 1'b1;
            default: begin
              wr_en = 1'b1;
              trig  = (cur_len + 16'd1) == LL;
            end
          endcase
        end
        if (trig) state_d = HDR;
      end
      HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = {sel_cl_q, sel_core_q, sel_len};
        out_last_o  = sel_len == '0;
        if (out_ready_i)
          state_d = (sel_len == '0) ? IDLE : PAY;
      end
      PAY: begin
        out_valid_o = 1'b1;
        out_data_o  = pay_word;
        out_last_o  = is_last;
        pay_hs      = out_ready_i;
        pay_done    = out_ready_i && is_last;
        if (pay_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      sel_cl_q   <= '0;
      sel_core_q <= '0;
      wcnt_q     <= '0;
      drop_q     <= '0;
      for (int s = 0; s < NSLOT; s++)
        len_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en)
        len_q[slot] <= cur_len + 16'd1;
      if (pay_done)
        len_q[sel_q] <= '0;
      if (trig) begin
        sel_q      <= slot;
        sel_cl_q   <= cl;
        sel_core_q <= core;
        wcnt_q     <= '0;
      end
      if (pay_hs)
        wcnt_q <= wcnt_q + 14'd1;
      if (drop_en && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  // Line storage needs no reset: bytes beyond len are never emitted.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      buf_q[slot][cur_len[BW-1:0]] <= ch;
  end

  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_stdout_line_assembler.sv
// Directed scoreboard bench for stdout_line_assembler.
// Two instances: default geometry and LINE_LEN=8.
module tb_stdout_line_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv   [2];
  logic        irdy [2];
  logic [31:0] id   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] od   [2];
  logic        ol   [2];
  logic [15:0] dc   [2];

  stdout_line_assembler dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv[0]), .in_ready_o(irdy[0]),
    .in_data_i(id[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
    .out_data_o(od[0]), .out_last_o(ol[0]),
    .drop_cnt_o(dc[0])
  );

  stdout_line_assembler #(.LINE_LEN(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(iv[1]), .in_ready_o(irdy[1]),
    .in_data_i(id[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
    .out_data_o(od[1]), .out_last_o(ol[1]),
    .drop_cnt_o(dc[1])
  );

  logic [32:0] obs0[$], obs1[$], exp0[$], exp1[$];
  int errors = 0;
  int checks = 0;
  int stab_viol = 0;
  int waits = 0;

  logic        pv, pr, pl;
  logic [31:0] pd;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!ov[0] || od[0] !== pd || ol[0] !== pl))
        stab_viol++;
      pv = ov[0]; pr = ordy[0]; pd = od[0]; pl = ol[0];
    end
    if (ov[0] && ordy[0]) obs0.push_back({ol[0], od[0]});
    if (ov[1] && ordy[1]) obs1.push_back({ol[1], od[1]});
  end

  task automatic chk(input string tag, input logic [63:0] o, e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  function automatic int osz(input int d);
    return (d == 0) ? obs0.size() : obs1.size();
  endfunction

  function automatic int esz(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic expw(input int d, input logic [31:0] w, input logic l);
    if (d == 0) exp0.push_back({l, w});
    else        exp1.push_back({l, w});
  endtask

  // Holds valid high; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [7:0] c, k, ch);
    int n;
    n = 0;
    iv[d] = 1'b1;
    id[d] = {8'hA5, c, k, ch};
    do begin
      @(negedge clk);
      n++;
    end while (!irdy[d] && n < 200);
    waits += n;
    if (!irdy[d]) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    iv[d] = 1'b0;
    id[d] = '0;
  endtask

  task automatic drain(input int d, input string tag);
    int n;
    logic [32:0] o, e;
    n = 0;
    while (osz(d) < esz(d) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("%s_cnt", tag), 64'(osz(d)), 64'(esz(d)));
    while (osz(d) > 0 && esz(d) > 0) begin
      if (d == 0) begin
        o = obs0.pop_front(); e = exp0.pop_front();
      end else begin
        o = obs1.pop_front(); e = exp1.pop_front();
      end
      chk(tag, 64'(o), 64'(e));
    end
    if (d == 0) begin obs0.delete(); exp0.delete(); end
    else        begin obs1.delete(); exp1.delete(); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b1;
    end
    #2;
    chk("rst_in_ready", 64'(irdy[0]), 0);
    chk("rst_out_valid", 64'(ov[0]), 0);
    chk("rst_out_data", 64'(od[0]), 0);
    chk("rst_out_last", 64'(ol[0]), 0);
    chk("rst_drop", 64'(dc[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_in_ready", 64'(irdy[0]), 1);

    // "Hi\n" on (1,2), then empty line proves len cleared
    expw(0, 32'h01020002, 0);
    expw(0, 32'h00006948, 1);
    expw(0, 32'h01020000, 1);
    send(0, 1, 2, "H");
    send(0, 1, 2, "i");
    send(0, 1, 2, 8'h0A);
    send(0, 1, 2, 8'h0A);
    idle(0);
    drain(0, "hi");

    // interleaved cores
    expw(0, 32'h00010002, 0);
    expw(0, 32'h00006463, 1);
    expw(0, 32'h00000002, 0);
    expw(0, 32'h00006261, 1);
    send(0, 0, 0, "a");
    send(0, 0, 0, "b");
    send(0, 0, 1, "c");
    send(0, 0, 1, "d");
    send(0, 0, 1, 8'h0A);
    send(0, 0, 0, 8'h0A);
    idle(0);
    drain(0, "ilv");

    // lone newline on (3,7), exact cycle timing
    expw(0, 32'h03070000, 1);
    send(0, 3, 7, 8'h0A);
    idle(0);
    chk("lone_valid", 64'(ov[0]), 1);
    chk("lone_word", 64'({ol[0], od[0]}), 64'({1'b1, 32'h03070000}));
    chk("lone_stall_in", 64'(irdy[0]), 0);
    @(posedge clk);
    #1;
    chk("lone_resume", 64'({irdy[0], ov[0]}), 64'(2'b10));
    drain(0, "lone");

    // out-of-range indices dropped
    send(0, 4, 0, "z");
    idle(0);
    repeat (3) @(posedge clk);
    #1 chk("drop_cl", 64'(dc[0]), 1);
    send(0, 0, 8, "z");
    idle(0);
    repeat (3) @(posedge clk);
    #1 chk("drop_core", 64'(dc[0]), 2);
    chk("drop_noout", 64'(osz(0)), 0);

    // 10-byte line with random output stalls
    expw(0, 32'h0105000A, 0);
    expw(0, 32'h33323130, 0);
    expw(0, 32'h37363534, 0);
    expw(0, 32'h00003938, 1);
    waits = 0;
    for (int i = 0; i < 10; i++)
      send(0, 1, 5, 8'h30 + 8'(i));
    chk("throughput", 64'(waits), 10);
    send(0, 1, 5, 8'h0A);
    idle(0);
    for (int n = 0; n < 300 && osz(0) < 4; n++) begin
      ordy[0] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    drain(0, "stall");
    chk("stall_stable", 64'(stab_viol), 0);

    // LINE_LEN=8 instance: full buffer flushes
    expw(1, 32'h00000008, 0);
    expw(1, 32'h44434241, 0);
    expw(1, 32'h48474645, 1);
    expw(1, 32'h00000001, 0);
    expw(1, 32'h00000049, 1);
    for (int i = 0; i < 9; i++)
      send(1, 0, 0, 8'h41 + 8'(i));
    send(1, 0, 0, 8'h0A);
    idle(1);
    drain(1, "full");

    // reset during payload
    expw(0, 32'h02030008, 0);
    ordy[0] = 1'b0;
    for (int i = 0; i < 8; i++)
      send(0, 2, 3, 8'h61 + 8'(i));
    send(0, 2, 3, 8'h0A);
    idle(0);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    chk("pay_valid", 64'(ov[0]), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abort_valid", 64'(ov[0]), 0);
    chk("rst_abort_rdy", 64'(irdy[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_drop_clr", 64'(dc[0]), 0);
    ordy[0] = 1'b1;
    drain(0, "rst_hdr");
    expw(0, 32'h02030001, 0);
    expw(0, 32'h00000078, 1);
    send(0, 2, 3, "x");
    send(0, 2, 3, 8'h0A);
    idle(0);
    drain(0, "rst_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stdout_line_assembler.md
# stdout_line_assembler

Drains the 32-bit character words produced by the stdout APB slave's FIFO (`{8'b0, cl_idx[7:0], core_idx[7:0], char[7:0]}`, first-word-fall-through). It keeps one line buffer per (cluster, core) and emits each completed line as a framed 32-bit packet toward the host-side stdout DMA/stream. Lines are completed by a newline or by the buffer filling, so interleaved output from different cores stays separated per line.

## Interface
- `N_CLUSTERS`, default 4: number of clusters; legal range 1..16.
- `N_CORES`, default 8: cores per cluster; legal range 1..16.
- `LINE_LEN`, default 128: bytes per line buffer; multiple of 4; legal range 4..65532.
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `in_valid_i`  in  1  FIFO word available (FIFO `data_valid`/`!empty`).
- `in_ready_o`  out  1  word consumed this cycle when high with `in_valid_i` (drives FIFO `rd_en`).
- `in_data_i`  in  32  FIFO word: [23:16] cluster, [15:8] core, [7:0] character; [31:24] ignored.
- `out_valid_o`  out  1  output word valid.
- `out_ready_i`  in  1  downstream accepts the word.
- `out_data_o`  out  32  header or payload word.
- `out_last_o`  out  1  last word of the packet.
- `drop_cnt_o`  out  16  saturating count of words dropped for an out-of-range index.

## Operation
- Storage: `N_CLUSTERS*N_CORES` slots of `LINE_LEN` bytes each, plus a 16-bit length per slot. Slot index = `cl*N_CORES + core`.
- FSM states: IDLE, HDR, PAY.
- IDLE:
  - `in_ready_o`=1.
  - On handshake with index out of range: drop the word; `drop_cnt_o`+=1, saturating at 0xFFFF.
  - On handshake with char ≠ 0x0A: write the byte at `len[slot]` and increment `len[slot]`. If the new length equals `LINE_LEN`, latch the slot and go to HDR.
  - On handshake with char = 0x0A: the byte is not stored. Latch the slot and go to HDR, including when `len`=0 (empty line).
- HDR:
  - `in_ready_o`=0.
  - `out_data_o` = `{cl[7:0], core[7:0], len[15:0]}` of the latched slot.
  - `out_last_o`=1 iff len=0.
  - On handshake: go to PAY if len>0; otherwise clear nothing and go to IDLE.
- PAY:
  - `in_ready_o`=0.
  - Word k carries bytes 4k..4k+3, little-endian (byte 4k in [7:0]). Bytes at or beyond len read as 0x00.
  - Word count = ceil(len/4). `out_last_o`=1 on word ceil(len/4)-1.
  - On the last handshake: `len[slot]`←0 and go to IDLE.
- Other slots keep their partial contents across any packet emission.
- Buffer reads use an asynchronous read of a flop array, or an equivalent that adds no bubble.

## Timing
- Reset values:
  - State IDLE; `in_ready_o`=1 after reset deassertion; 0 while `rst_ni`=0.
  - `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `drop_cnt_o`=0.
  - All lengths 0. Buffer contents are don't-care.
- Throughput: IDLE accepts one character per cycle.
- Triggering character accepted in cycle t:
  - HDR is valid in cycle t+1.
  - The first payload word is valid the cycle after the header handshake.
  - With `out_ready_i` held high: one word per cycle.
  - IDLE resumes, and `in_ready_o`=1, the cycle after the last handshake.
- Output rule: `out_data_o`/`out_last_o` must hold stable while `out_valid_o`=1 and `out_ready_i`=0. `out_valid_o` never drops without a handshake.
- Input is fully stalled during HDR and PAY. FIFO backpressure then propagates to the APB slave's `pready`.
- Reset asserted mid-packet: the packet is abandoned immediately (`out_valid_o`→0 asynchronously), all lengths are cleared, and no partial packet is resumed.
- `in_valid_i` is ignored when `in_ready_o`=0.

## Test plan
- Cluster 1, core 2 sends "Hi\n":
  - Header 0x01020002, last=0.
  - Payload 0x00006948, last=1.
  - Slot length afterwards is 0.
- Interleaving core(0,0) "ab", core(0,1) "cd\n", core(0,0) "\n":
  - First packet: 0x00010002, 0x00006463.
  - Second packet: 0x00000002, 0x00006261.
- Lone "\n" on core(3,7):
  - Single word 0x03070000 with last=1.
  - IDLE resumes the next cycle.
- `LINE_LEN`=8, core(0,0) sends 9 chars 'A'..'I':
  - After 'H', header 0x00000008, then 0x44434241 and 0x48474645 (last).
  - 'I' is then stored, giving `len`=1.
- Index cl=N_CLUSTERS:
  - Word is dropped; `drop_cnt_o`=1; no output.
  - Random `out_ready_i` stalls during a 10-byte line: data stays stable under stall, and 1 header + 3 payload words are emitted with the last word = 0x0000'xxxx (upper bytes zero).
- `rst_ni` pulsed low during PAY:
  - `out_valid_o`=0 at once.
  - After release, "x\n" on the same core yields header len=1, so the old bytes are not resent.
